sound_sequencer: RTL and testbench



---
 rtl/sound_pkg.sv | 50 +++++
 rtl/sound_voice.sv | 89 ++++++++
 rtl/sound_sequencer.sv | 125 ++++++++++++
 tb/tb_sound_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared types, default parameters and the note pattern for the sound sequencer.
package sound_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_e;

    localparam int DEF_NUM_VOICES      = 2;
    localparam int DEF_PERIOD_W        = 5;
    localparam int DEF_STEPS           = 16;
    localparam int DEF_FRAMES_PER_STEP = 4;
    localparam int DEF_ENV_W           = 5;
    localparam int DEF_DECAY           = 8;
    localparam int DEF_ENV_SHIFT       = 3;
    localparam int DEF_X_BASE          = 256;
    localparam int X_W                 = 10;

    // Half-period (in lines, minus one) for a voice at a step; 0 is a rest.
    // Voice 1 plays the lower octave, 2p+1, clamped to the largest divider
    // value where the true octave does not fit.
    function automatic logic [7:0] note_period(input int voice, input int step);
        int base;
        int low;
        case (step % 16)
            0:       base = 28;
            1:       base = 25;
            2:       base = 24;
            4:       base = 13;
            5:       base = 12;
            6:       base = 11;
            8:       base = 9;
            9:       base = 8;
            10:      base = 7;
            12:      base = 5;
            13:      base = 4;
            14:      base = 3;
            default: base = 0;
        endcase
        if (voice == 0 || base == 0) begin
            return 8'(base);
        end
        low = 2 * base + 1;
        if (low > (2 ** DEF_PERIOD_W) - 1) begin
            low = (2 ** DEF_PERIOD_W) - 1;
        end
        return 8'(low);
    endfunction

endpackage

// File: rtl/sound_voice.sv
// One square-wave voice: line-rate divider, phase, decaying envelope and the
// pixel-column window that turns the envelope into a PWM loudness.
module sound_voice
    import sound_pkg::*;
#(
    parameter int PERIOD_W  = DEF_PERIOD_W,
    parameter int ENV_W     = DEF_ENV_W,
    parameter int DECAY     = DEF_DECAY,
    parameter int ENV_SHIFT = DEF_ENV_SHIFT,
    parameter int X_BASE    = DEF_X_BASE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [PERIOD_W-1:0] period_load,
    input  logic                frame_tick,
    input  logic                line_tick,
    input  logic                enable,
    input  logic [X_W-1:0]      x,
    output logic                out
);

    // One extra bit over x plus the shift keeps base + window from wrapping.
    localparam int CMP_W = X_W + ENV_SHIFT + 1;
    localparam int ENV_MAX = (2 ** ENV_W) - 1;
    localparam logic [ENV_W-1:0] ENV_FULL = '1;
    // A decay larger than the envelope range simply empties it in one frame.
    localparam logic [ENV_W-1:0] DECAY_SAT = (DECAY > ENV_MAX) ? ENV_FULL : ENV_W'(DECAY);

    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic [ENV_W-1:0]    env_q, env_d;

    logic [CMP_W-1:0] x_ext, win_lo, win_hi;

    // Divider and phase: step entry reloads, otherwise advance on each line.
    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        if (load) begin
            period_d = period_load;
            cnt_d    = '0;
            phase_d  = 1'b0;
        end else if (line_tick) begin
            if (period_q == '0) begin
                cnt_d   = '0;
                phase_d = 1'b0;
            end else if (cnt_q == period_q) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Envelope: full on step entry, saturating decay once per frame.
    always_comb begin
        env_d = env_q;
        if (load) begin
            env_d = ENV_FULL;
        end else if (frame_tick) begin
            env_d = (env_q > DECAY_SAT) ? (env_q - DECAY_SAT) : '0;
        end
    end

    // Voice state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            env_q    <= '0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            env_q    <= env_d;
        end
    end

    assign x_ext  = CMP_W'(x);
    assign win_lo = CMP_W'(X_BASE);
    assign win_hi = win_lo + (CMP_W'(env_q) << ENV_SHIFT);
    assign out    = phase_q & enable & (x_ext >= win_lo) & (x_ext < win_hi);

endmodule

// File: rtl/sound_sequencer.sv
// Multi-voice pattern sequencer: IDLE/PLAY control, frame and step counting,
// and the registered OR mix of the voices onto the one-bit sound output.
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int NUM_VOICES      = DEF_NUM_VOICES,
    parameter int PERIOD_W        = DEF_PERIOD_W,
    parameter int STEPS           = DEF_STEPS,
    parameter int FRAMES_PER_STEP = DEF_FRAMES_PER_STEP,
    parameter int ENV_W           = DEF_ENV_W,
    parameter int DECAY           = DEF_DECAY,
    parameter int ENV_SHIFT       = DEF_ENV_SHIFT,
    parameter int X_BASE          = DEF_X_BASE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_tick,
    input  logic                       line_tick,
    input  logic [X_W-1:0]             x,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop,
    input  logic [NUM_VOICES-1:0]      voice_mask,
    output logic                       sound,
    output logic                       playing,
    output logic [$clog2(STEPS)-1:0]   step
);

    localparam int STEP_W = $clog2(STEPS);
    localparam int FCNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(STEPS - 1);
    localparam logic [FCNT_W-1:0] LAST_FRAME = FCNT_W'(FRAMES_PER_STEP - 1);

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                sound_q, sound_d;
    logic                entry;
    logic [NUM_VOICES-1:0] voice_out;

    // Control FSM and step timing; stop outranks start, start outranks ticks.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        fcnt_d  = fcnt_q;
        entry   = 1'b0;
        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = PLAY;
            step_d  = '0;
            fcnt_d  = '0;
            entry   = 1'b1;
        end else if (state_q == PLAY && frame_tick) begin
            if (fcnt_q == LAST_FRAME) begin
                fcnt_d = '0;
                if (step_q == LAST_STEP) begin
                    if (loop) begin
                        step_d = '0;
                        entry  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    step_d = step_q + 1'b1;
                    entry  = 1'b1;
                end
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Mix only while playing across this edge, so start/stop land silent.
    always_comb begin
        sound_d = 1'b0;
        if (state_q == PLAY && state_d == PLAY) begin
            sound_d = |voice_out;
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            fcnt_q  <= '0;
            sound_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            fcnt_q  <= fcnt_d;
            sound_q <= sound_d;
        end
    end

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
        logic [PERIOD_W-1:0] period_load;
        // The voice loads the period of the step being entered.
        assign period_load = PERIOD_W'(note_period(gi, int'(step_d)));

        sound_voice #(
            .PERIOD_W  (PERIOD_W),
            .ENV_W     (ENV_W),
            .DECAY     (DECAY),
            .ENV_SHIFT (ENV_SHIFT),
            .X_BASE    (X_BASE)
        ) u_voice (
            .clk         (clk),
            .rst         (rst),
            .load        (entry),
            .period_load (period_load),
            .frame_tick  (frame_tick),
            .line_tick   (line_tick),
            .enable      (voice_mask[gi]),
            .x           (x),
            .out         (voice_out[gi])
        );
    end

    assign sound   = sound_q;
    assign playing = (state_q == PLAY);
    assign step    = step_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Scoreboard bench for sound_sequencer on a shrunken raster (20 lines of
// 8 cycles per frame) with x probing the window boundaries.
module tb_sound_sequencer;

    localparam int LPF = 20;
    localparam int CPL = 8;
    localparam int NX  = 14;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic       line_tick;
    logic [9:0] x;
    logic       start;
    logic       stop;
    logic       loop;
    logic [1:0] voice_mask;
    logic       sound;
    logic       playing;
    logic [3:0] step;

    sound_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .line_tick  (line_tick),
        .x          (x),
        .start      (start),
        .stop       (stop),
        .loop       (loop),
        .voice_mask (voice_mask),
        .sound      (sound),
        .playing    (playing),
        .step       (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       snd;
        logic       ply;
        logic [3:0] stp;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Hand-written note tables (lines per half period minus one).
    int P0[16] = '{28, 25, 24, 0, 13, 12, 11, 0, 9, 8, 7, 0, 5, 4, 3, 0};
    int P1[16] = '{31, 31, 31, 0, 27, 25, 23, 0, 19, 17, 15, 0, 11, 9, 7, 0};
    int XTAB[NX] = '{255, 256, 257, 311, 312, 375, 376, 439, 440, 503, 504, 700, 300, 480};

    // Pending control values, applied at the next driven cycle.
    logic       c_rst = 1'b1;
    logic       c_loop = 1'b0;
    logic [1:0] c_mask = 2'b00;

    // Reference state: lines/frames elapsed since the last step entry.
    bit m_play = 0;
    int m_step = 0;
    int m_fcnt = 0;
    int m_lines = 0;
    int m_frames = 0;

    function automatic bit voice_on(input int v, input int xv, input bit en);
        int p;
        int env;
        bit ph;
        p   = (v == 0) ? P0[m_step] : P1[m_step];
        ph  = (p != 0) && (((m_lines / (p + 1)) % 2) == 1);
        env = 31 - 8 * m_frames;
        if (env < 0) env = 0;
        return ph && en && (xv >= 256) && (xv < 256 + env * 8);
    endfunction

    task automatic drive(input bit ft, input bit lt, input int xv, input bit st, input bit sp);
        bit   nplay;
        int   nstep;
        int   nfcnt;
        bit   entry;
        bit   vout;
        exp_t e;
        @(negedge clk);
        rst        = c_rst;
        loop       = c_loop;
        voice_mask = c_mask;
        frame_tick = ft;
        line_tick  = lt;
        x          = 10'(xv);
        start      = st;
        stop       = sp;
        if (c_rst) begin
            m_play = 0; m_step = 0; m_fcnt = 0; m_lines = 0; m_frames = 0;
            e = '{snd: 1'b0, ply: 1'b0, stp: 4'd0};
            exp_q.push_back(e);
            return;
        end
        vout  = voice_on(0, xv, c_mask[0]) || voice_on(1, xv, c_mask[1]);
        nplay = m_play; nstep = m_step; nfcnt = m_fcnt; entry = 0;
        if (sp) begin
            nplay = 0;
        end else if (st) begin
            nplay = 1; nstep = 0; nfcnt = 0; entry = 1;
        end else if (m_play && ft) begin
            if (m_fcnt == 3) begin
                nfcnt = 0;
                if (m_step == 15) begin
                    if (c_loop) begin nstep = 0; entry = 1; end
                    else nplay = 0;
                end else begin
                    nstep = m_step + 1; entry = 1;
                end
            end else begin
                nfcnt = m_fcnt + 1;
            end
        end
        e.snd = m_play && nplay && vout;
        e.ply = nplay;
        e.stp = 4'(nstep);
        exp_q.push_back(e);
        if (entry) begin
            m_lines = 0; m_frames = 0;
        end else begin
            if (lt) m_lines++;
            if (ft && m_frames < 100) m_frames++;
        end
        m_play = nplay; m_step = nstep; m_fcnt = nfcnt;
    endtask

    task automatic run_frames(input int n);
        for (int f = 0; f < n; f++)
            for (int l = 0; l < LPF; l++)
                for (int c = 0; c < CPL; c++)
                    drive(l == 0 && c == 0, c == 0, (c == 0) ? 0 : XTAB[(l * 5 + c) % NX], 1'b0, 1'b0);
    endtask

    task automatic ctrl(input bit st, input bit sp);
        drive(1'b0, 1'b0, 300, st, sp);
    endtask

    int err_mark = 0;
    task automatic report(input string name);
        $display("[%0d] %s: checks=%0d new_errors=%0d step=%0d playing=%0b",
                 cyc, name, n_checks, n_errors - err_mark, step, playing);
        err_mark = n_errors;
    endtask

    // Monitor: every edge presents an output word; compare against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (sound !== e.snd) begin
                    n_errors++;
                    $display("FAIL sound cycle=%0d x=%0d got=%b exp=%b", cyc, x, sound, e.snd);
                end
                n_checks++;
                if (playing !== e.ply) begin
                    n_errors++;
                    $display("FAIL playing cycle=%0d got=%b exp=%b", cyc, playing, e.ply);
                end
                n_checks++;
                if (step !== e.stp) begin
                    n_errors++;
                    $display("FAIL step cycle=%0d got=%0d exp=%0d", cyc, step, e.stp);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; frame_tick = 1'b0; line_tick = 1'b0; x = '0;
        start = 1'b0; stop = 1'b0; loop = 1'b0; voice_mask = 2'b00;

        // Reset for two cycles, then idle frames with no start.
        c_rst = 1'b1;
        ctrl(1'b0, 1'b0);
        ctrl(1'b0, 1'b0);
        c_rst = 1'b0;
        c_mask = 2'b11;
        run_frames(100);
        report("reset_idle");

        // Voice 0 only, no loop: full pattern then playback ends.
        c_mask = 2'b01; c_loop = 1'b0;
        ctrl(1'b1, 1'b0);
        run_frames(66);
        report("voice0_noloop_end");

        // Voice 1 only with loop: wraps to step 0 and keeps playing.
        c_mask = 2'b10; c_loop = 1'b1;
        ctrl(1'b1, 1'b0);
        run_frames(68);
        report("voice1_loop_wrap");
        c_mask = 2'b11;
        run_frames(6);
        report("both_voices");

        // start and stop together: stop wins.
        ctrl(1'b1, 1'b1);
        run_frames(2);
        report("start_stop_collision");

        // Restart during step 7.
        ctrl(1'b1, 1'b0);
        run_frames(29);
        ctrl(1'b1, 1'b0);
        run_frames(6);
        report("restart_mid_step7");

        // Plain stop.
        ctrl(1'b0, 1'b1);
        run_frames(1);
        report("stop");

        // Reset in the middle of playback.
        c_mask = 2'b01;
        ctrl(1'b1, 1'b0);
        run_frames(10);
        c_rst = 1'b1;
        ctrl(1'b0, 1'b0);
        c_rst = 1'b0;
        run_frames(2);
        report("reset_mid_play");

        // Drain the scoreboard within a bounded number of edges.
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain leftover=%0d required=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
